// File: rtl/bist_pkg.sv
// Shared types and March C- element table for the BIST sequencer.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic is_read;
        logic value_is_ones;
    } march_op_t;

    localparam int unsigned MARCH_ELEMS = 6;
    localparam int unsigned ELEM_W      = 3;
    localparam int unsigned OPS_PER_EL  = 2;

    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(MARCH_ELEMS - 1);

    // Bit e set: element e walks N-1 down to 0
    localparam logic [MARCH_ELEMS-1:0] ELEM_DOWN    = 6'b011000;
    // Bit e set: element e has two operations (read then write)
    localparam logic [MARCH_ELEMS-1:0] ELEM_TWO_OPS = 6'b011110;

    // Op list indexed by {elem, op}; unused second slots of M0/M5 are don't-care
    localparam march_op_t [OPS_PER_EL*MARCH_ELEMS-1:0] ELEM_OPS =
        24'b00_10_00_11_01_10_00_11_01_10_00_00;

    function automatic march_op_t march_op(input logic [ELEM_W-1:0] elem,
                                           input logic              op_idx);
        return ELEM_OPS[{elem, op_idx}];
    endfunction

endpackage

// File: rtl/bist_march_controller_addr_gen.sv
// Loadable up/down address counter with terminal-address flag.
module bist_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    input  logic                  down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  at_end_c
);

    assign at_end_c = down ? (addr == '0) : (addr == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/bist_march_controller.sv
// March C- BIST sequencer driving the test side of the memory mux,
// with one-cycle-delayed read compare and first-fail capture.
module bist_march_controller
    import bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  NbarT,
    output logic [ADDR_WIDTH-1:0] bist_addr,
    output logic [DATA_WIDTH-1:0] bist_data,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element
);

    state_e              state, state_n;
    logic [ELEM_W-1:0]   elem, elem_n;
    logic                op_idx, op_n;
    march_op_t           op_nx;

    logic                ag_load, ag_load_down, ag_step, ag_down;
    logic                at_end_c;

    logic                nbart_n, we_n, re_n, done_n, fail_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [ADDR_WIDTH-1:0] fail_addr_n;
    logic [2:0]            fail_elem_n;

    logic                  cmp_valid;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [ELEM_W-1:0]     cmp_elem;
    logic                  mismatch_c;

    assign ag_down    = ELEM_DOWN[elem];
    assign mismatch_c = cmp_valid && (mem_rdata != exp_q);

    bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (ag_down),
        .addr      (bist_addr),
        .at_end_c  (at_end_c)
    );

    // Next state, sequencing indices and next values of registered outputs
    always_comb begin
        state_n      = state;
        elem_n       = elem;
        op_n         = op_idx;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        done_n       = done;
        fail_n       = fail;
        fail_addr_n  = fail_addr;
        fail_elem_n  = fail_element;

        if (mismatch_c && !fail) begin
            fail_n      = 1'b1;
            fail_addr_n = cmp_addr;
            fail_elem_n = cmp_elem;
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n      = RUN;
                    elem_n       = '0;
                    op_n         = 1'b0;
                    ag_load      = 1'b1;
                    ag_load_down = ELEM_DOWN[0];
                    done_n       = 1'b0;
                    fail_n       = 1'b0;
                    fail_addr_n  = '0;
                    fail_elem_n  = '0;
                end
            end
            RUN: begin
                if (!op_idx && ELEM_TWO_OPS[elem]) begin
                    op_n = 1'b1;
                end else begin
                    op_n = 1'b0;
                    if (at_end_c) begin
                        if (elem == ELEM_LAST) begin
                            state_n = DRAIN;
                        end else begin
                            elem_n       = elem + ELEM_W'(1);
                            ag_load      = 1'b1;
                            ag_load_down = ELEM_DOWN[elem_n];
                        end
                    end else begin
                        ag_step = 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_n = DONE;
                done_n  = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        op_nx   = march_op(elem_n, op_n);
        nbart_n = (state_n == RUN) || (state_n == DRAIN);
        we_n    = (state_n == RUN) && !op_nx.is_read;
        re_n    = (state_n == RUN) &&  op_nx.is_read;
        data_n  = ((state_n == RUN) && op_nx.value_is_ones) ? '1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            elem         <= '0;
            op_idx       <= 1'b0;
            NbarT        <= 1'b0;
            bist_data    <= '0;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_element <= '0;
            cmp_valid    <= 1'b0;
            exp_q        <= '0;
            cmp_addr     <= '0;
            cmp_elem     <= '0;
        end else begin
            state        <= state_n;
            elem         <= elem_n;
            op_idx       <= op_n;
            NbarT        <= nbart_n;
            bist_data    <= data_n;
            mem_we       <= we_n;
            mem_re       <= re_n;
            done         <= done_n;
            fail         <= fail_n;
            fail_addr    <= fail_addr_n;
            fail_element <= fail_elem_n;
            // Expected value travels with the read; compared when data returns
            cmp_valid    <= mem_re;
            exp_q        <= bist_data;
            cmp_addr     <= bist_addr;
            cmp_elem     <= elem;
        end
    end

endmodule
